vdp2_showahead_fifo: RTL and testbench
======================================

Name: vdp2_showahead_fifo

Overview:
- Small synchronous show-ahead (first-word-fall-through) FIFO that buffers VDP2 register/VRAM write requests (address+data+byte enables packed into one word) between the CPU bus side and the VDP2 memory arbiter.
- Both sides run on one clock.
- The head word is always presented on Q without a read request; RDREQ acknowledges and pops it.
- Storage is a small register/LUT-RAM array with no output register.

Parameters:
- WIDTH, 36, width of each stored word in bits.
- DEPTH_LOG2, 3, log2 of entry count; depth = 2**DEPTH_LOG2 = 8.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  asynchronous active-high reset.
- DATA  input  WIDTH  word to enqueue.
- WRREQ  input  1  write request, sampled at CLK rising edge.
- RDREQ  input  1  read/pop acknowledge, sampled at CLK rising edge.
- Q  output  WIDTH  head-of-queue word (show-ahead, combinational from storage and read pointer).
- EMPTY  output  1  high when the FIFO holds 0 words.
- FULL  output  1  high when the FIFO holds DEPTH words.
- USEDW  output  DEPTH_LOG2+1  current word count, 0..DEPTH.

Behaviour:
- Reset (RST=1, asynchronous): write ptr=0, read ptr=0, count=0, so EMPTY=1, FULL=0, USEDW=0. Storage contents are not cleared.
- Q is don't-care while EMPTY=1; benches must not check it then.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH naturally. The count is a separate DEPTH_LOG2+1-bit register.
- EMPTY = (count==0), FULL = (count==DEPTH), USEDW = count. All are derived from registers, with no combinational path from WRREQ/RDREQ.
- Write accepted = WRREQ & ~FULL. When accepted, mem[wr_ptr] <= DATA and wr_ptr increments at the edge.
- Read accepted = RDREQ & ~EMPTY. When accepted, rd_ptr increments at the edge and Q shows the next word immediately after that edge.
- Overflow/underflow protection is built in:
  - WRREQ while FULL (without an accepted read) is ignored; data is dropped and no state changes.
  - RDREQ while EMPTY is ignored.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous WRREQ & RDREQ:
  - Not empty and not full: both accepted, count unchanged.
  - FULL: the read is accepted, and the write is also accepted because a slot frees in the same edge. wr_ptr==rd_ptr, so the popped slot is written; the read uses the old value. Count stays DEPTH.
  - EMPTY: only the write is accepted (no bypass). Count becomes 1, and Q shows DATA in the next cycle.
- Latency:
  - Write at edge N: EMPTY falls and Q=DATA from just after edge N, usable in cycle N+1.
  - Read at edge N: Q advances just after edge N.
- The fall-through path is not registered: Q = mem[rd_ptr], an asynchronous read of the array.
- RST asserted mid-operation: queue contents are abandoned immediately, regardless of pending WRREQ/RDREQ. Operation resumes on the first edge after RST deasserts.
- Inputs carrying X while the request is low must not corrupt state.

Test Plan:
- Reset then idle: assert RST, release → EMPTY=1, FULL=0, USEDW=0 each cycle. RDREQ=1 for 3 cycles → no change.
- Single word fall-through: write 36'h0_1234_5678 in one cycle → next cycle EMPTY=0, USEDW=1, Q=36'h012345678. RDREQ one cycle → EMPTY=1, USEDW=0.
- Fill/overflow: write 9 words 36'h1..36'h9 back-to-back →
  - FULL=1 after the 8th, USEDW=8.
  - The 9th is dropped.
  - Pop 8 → Q sequence 1..8, EMPTY=1 after the last.
- Wrap-around ordering: repeat write 5/read 5 in three rounds, with values incrementing across rounds (pointers wrap past 7) → reads return strictly ascending values 1..15, no loss.
- Simultaneous read+write:
  - When FULL (contents 1..8), write 36'hA with RDREQ → FULL stays 1, Q becomes 2. Draining gives 2..8 then A.
  - When EMPTY, write 36'hB with RDREQ → USEDW=1, Q=36'hB next cycle.
- Async reset mid-stream: with 4 words stored, pulse RST between clock edges → EMPTY=1 and USEDW=0 before the next edge. A subsequent write of 36'hC appears alone at Q.

Source files
------------

// File: rtl/vdp2_showahead_fifo.sv
// Show-ahead (first-word-fall-through) FIFO for VDP2 write requests.
// The head word is read asynchronously from the array; RDREQ only pops it.
module vdp2_showahead_fifo #(
    parameter int WIDTH      = 36,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WIDTH-1:0]      DATA,
    input  logic                  WRREQ,
    input  logic                  RDREQ,
    output logic [WIDTH-1:0]      Q,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic [DEPTH_LOG2:0]   USEDW
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO   = '0;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL   = CNT_ONE << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  rd_en;
    logic                  wr_en;

    assign EMPTY = (count == CNT_ZERO);
    assign FULL  = (count == CNT_FULL);
    assign USEDW = count;
    assign Q     = mem[rd_ptr];

    // A pop on a full FIFO frees the head slot in the same edge, so the write may proceed.
    assign rd_en = RDREQ & ~EMPTY;
    assign wr_en = WRREQ & (~FULL | rd_en);

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_en && !rd_en) begin
                count <= count + CNT_ONE;
            end else if (rd_en && !wr_en) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_vdp2_showahead_fifo.sv
// Directed table-driven bench for vdp2_showahead_fifo plus hand-written reset sequences.
module tb_vdp2_showahead_fifo;

    logic        CLK;
    logic        RST;
    logic [35:0] DATA;
    logic        WRREQ;
    logic        RDREQ;
    logic [35:0] Q;
    logic        EMPTY;
    logic        FULL;
    logic [3:0]  USEDW;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [35:0] data;
        logic        e;
        logic        f;
        logic [3:0]  u;
        logic        cq;
        logic [35:0] q;
    } vec_t;

    vec_t tbl[$];

    vdp2_showahead_fifo #(.WIDTH(36), .DEPTH_LOG2(3)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .DATA  (DATA),
        .WRREQ (WRREQ),
        .RDREQ (RDREQ),
        .Q     (Q),
        .EMPTY (EMPTY),
        .FULL  (FULL),
        .USEDW (USEDW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic add(input logic wr, input logic rd, input logic [35:0] d,
                       input logic e, input logic f, input int u,
                       input logic cq, input logic [35:0] q);
        vec_t v;
        v.wr = wr; v.rd = rd; v.data = d; v.e = e; v.f = f;
        v.u = 4'(u); v.cq = cq; v.q = q;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string name, input logic e, input logic f, input int u);
        chk({name, ".EMPTY"}, 36'(EMPTY), 36'(e));
        chk({name, ".FULL"},  36'(FULL),  36'(f));
        chk({name, ".USEDW"}, 36'(USEDW), 36'(u));
    endtask

    task automatic step(input logic wr, input logic rd, input logic [35:0] d);
        WRREQ = wr; RDREQ = rd; DATA = d;
        @(posedge CLK);
        #1;
        WRREQ = 1'b0; RDREQ = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        WRREQ = 1'b0; RDREQ = 1'b0; DATA = '0;

        // Underflow on an idle FIFO
        for (int i = 0; i < 3; i++) add(0, 1, 36'h0, 1, 0, 0, 0, 36'h0);
        // Single word fall-through
        add(1, 0, 36'h012345678, 0, 0, 1, 1, 36'h012345678);
        add(0, 1, 36'h0, 1, 0, 0, 0, 36'h0);
        // Fill and overflow: ninth word dropped
        for (int k = 1; k <= 8; k++) add(1, 0, 36'(k), 0, (k == 8), k, 1, 36'h1);
        add(1, 0, 36'h9, 0, 1, 8, 1, 36'h1);
        for (int j = 1; j <= 8; j++)
            add(0, 1, 36'h0, (j == 8), 0, 8 - j, (j < 8), 36'(j + 1));
        // Wrap-around ordering across three rounds
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i <= 5; i++) add(1, 0, 36'(5*r + i), 0, 0, i, 1, 36'(5*r + 1));
            for (int i = 1; i <= 5; i++)
                add(0, 1, 36'h0, (i == 5), 0, 5 - i, (i < 5), 36'(5*r + 1 + i));
        end
        // Simultaneous read+write while full
        for (int k = 1; k <= 8; k++) add(1, 0, 36'(k), 0, (k == 8), k, 1, 36'h1);
        add(1, 1, 36'hA, 0, 1, 8, 1, 36'h2);
        for (int j = 1; j <= 8; j++)
            add(0, 1, 36'h0, (j == 8), 0, 8 - j, (j < 8), (j < 7) ? 36'(j + 2) : 36'hA);
        // Simultaneous read+write while empty: write only, no bypass
        add(1, 1, 36'hB, 0, 0, 1, 1, 36'hB);
        // Idle with X on DATA must not disturb state
        add(0, 0, 36'hx, 0, 0, 1, 1, 36'hB);
        add(0, 1, 36'h0, 1, 0, 0, 0, 36'h0);

        // Reset and idle
        RST = 1'b1;
        #12;
        chk_status("in_reset", 1, 0, 0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #1;
            chk_status("idle_after_reset", 1, 0, 0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].data);
            chk_status($sformatf("vec%0d", i), tbl[i].e, tbl[i].f, tbl[i].u);
            if (tbl[i].cq) chk($sformatf("vec%0d.Q", i), Q, tbl[i].q);
        end

        // Async reset between edges with four words stored
        for (int k = 1; k <= 4; k++) step(1, 0, 36'(36'h100 + k));
        chk_status("pre_reset", 0, 0, 4);
        chk("pre_reset.Q", Q, 36'h101);
        #2 RST = 1'b1;
        #1;
        chk_status("async_reset", 1, 0, 0);
        #1 RST = 1'b0;
        step(1, 0, 36'hC);
        chk_status("after_reset_write", 0, 0, 1);
        chk("after_reset_write.Q", Q, 36'hC);
        step(0, 1, 36'h0);
        chk_status("after_reset_pop", 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
